// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: synchronizes a raw bouncing input, debounces press and
// release, and emits single-cycle press/repeat/release events with auto-repeat.
module btn_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 50000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter int unsigned REPEAT_EN       = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic pulse,
    output logic rel_pulse,
    output logic level,
    output logic held
);

    localparam int unsigned MAX_DR = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned MAX_P  = (DEBOUNCE_CYCLES > MAX_DR) ? DEBOUNCE_CYCLES : MAX_DR;
    localparam int          CNT_W  = (MAX_P > 2) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        PRESSED,
        REPEAT,
        RELEASE_DB
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] timer;
    logic             sync_p0;
    logic             btn_s;

    // Two-flop synchronizer; nothing else may look at btn_in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            sync_p0 <= btn_in;
            btn_s   <= sync_p0;
        end
    end

    // A btn_s change always wins over a terminal count reached in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            timer     <= '0;
            pulse     <= 1'b0;
            rel_pulse <= 1'b0;
            level     <= 1'b0;
            held      <= 1'b0;
        end else begin
            pulse     <= 1'b0;
            rel_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_DB;
                        cnt   <= ONE;
                    end
                end
                PRESS_DB: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        timer <= '0;
                        pulse <= 1'b1;
                        level <= 1'b1;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                PRESSED: begin
                    // With repeat disabled the timer is parked so it can never wrap.
                    if (!btn_s) begin
                        state <= RELEASE_DB;
                        cnt   <= ONE;
                    end else if (REPEAT_EN != 0 && timer == RD_LAST) begin
                        state <= REPEAT;
                        timer <= '0;
                        pulse <= 1'b1;
                        held  <= 1'b1;
                    end else if (REPEAT_EN != 0) begin
                        timer <= timer + ONE;
                    end
                end
                REPEAT: begin
                    if (!btn_s) begin
                        state <= RELEASE_DB;
                        cnt   <= ONE;
                        held  <= 1'b0;
                    end else if (timer == RP_LAST) begin
                        timer <= '0;
                        pulse <= 1'b1;
                    end else begin
                        timer <= timer + ONE;
                    end
                end
                RELEASE_DB: begin
                    if (btn_s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        timer <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        rel_pulse <= 1'b1;
                        level     <= 1'b0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    timer <= '0;
                    level <= 1'b0;
                    held  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse: two instances (repeat on/off) checked every cycle
// against a run-length behavioural model, plus directed literal scenarios.
module tb_btn_debounce_pulse;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic btn_in = 1'b0;
    logic pulse0, rel0, level0, held0;
    logic pulse1, rel1, level1, held1;

    int checks = 0;
    int fails  = 0;
    int pc0 = 0, pc1 = 0, rc0 = 0, rc1 = 0;
    bit held1_seen = 1'b0;

    always #5 clk = ~clk;

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1)
    ) dut_en (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .pulse(pulse0), .rel_pulse(rel0), .level(level0), .held(held0)
    );

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(0)
    ) dut_noen (
        .clk(clk), .reset(reset), .btn_in(btn_in),
        .pulse(pulse1), .rel_pulse(rel1), .level(level1), .held(held1)
    );

    // Model: level toggles once btn_s has disagreed with it for DB consecutive edges;
    // repeat events fall at t = RD + k*RP edges after the last (re)entry to pressed.
    bit en_m [2] = '{1'b1, 1'b0};
    bit lvl_m [2];
    bit pul_m [2];
    bit rel_m [2];
    bit hld_m [2];
    int run_m [2];
    int t_m   [2];
    bit d1 = 1'b0, d2 = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [3:0] outs(input int i);
        return (i == 0) ? {pulse0, rel0, level0, held0} : {pulse1, rel1, level1, held1};
    endfunction

    function automatic logic [3:0] model_outs(input int i);
        return {pul_m[i], rel_m[i], lvl_m[i], hld_m[i]};
    endfunction

    task automatic step(input int i, input bit s);
        pul_m[i] = 1'b0;
        rel_m[i] = 1'b0;
        if (!lvl_m[i]) begin
            run_m[i] = s ? run_m[i] + 1 : 0;
            if (run_m[i] == DB) begin
                lvl_m[i] = 1'b1;
                pul_m[i] = 1'b1;
                run_m[i] = 0;
                t_m[i]   = 0;
            end
        end else if (!s) begin
            hld_m[i] = 1'b0;
            run_m[i]++;
            if (run_m[i] == DB) begin
                lvl_m[i] = 1'b0;
                rel_m[i] = 1'b1;
                run_m[i] = 0;
            end
        end else if (run_m[i] != 0) begin
            run_m[i] = 0;
            t_m[i]   = 0;
        end else begin
            t_m[i]++;
            if (en_m[i] && t_m[i] >= RD && (t_m[i] - RD) % RP == 0) begin
                pul_m[i] = 1'b1;
                hld_m[i] = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            d1 = 1'b0;
            d2 = 1'b0;
            for (int i = 0; i < 2; i++) begin
                lvl_m[i] = 1'b0; pul_m[i] = 1'b0; rel_m[i] = 1'b0; hld_m[i] = 1'b0;
                run_m[i] = 0;    t_m[i]   = 0;
            end
        end else begin
            bit s;
            s  = d2;
            d2 = d1;
            d1 = btn_in;
            for (int i = 0; i < 2; i++) step(i, s);
        end
    end

    initial forever begin
        @(negedge clk);
        check("dut_en outputs", int'(outs(0)), int'(model_outs(0)));
        check("dut_noen outputs", int'(outs(1)), int'(model_outs(1)));
        if (pulse0) pc0++;
        if (pulse1) pc1++;
        if (rel0) rc0++;
        if (rel1) rc1++;
        if (held1) held1_seen = 1'b1;
    end

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            btn_in = v;
        end
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected self-termination");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit v;
        int c;
        v = 1'b0;
        c = 0;

        repeat (3) @(negedge clk);
        #1;
        check("reset_outs_en", int'(outs(0)), 0);
        check("reset_outs_noen", int'(outs(1)), 0);
        #1 reset = 1'b0;
        drive(0, 5);

        // Clean press and auto-repeat
        @(negedge clk);
        btn_in = 1'b1;
        #1 pc0 = 0; pc1 = 0; held1_seen = 1'b0;
        edges(5);
        check("press_e5_pulse", pulse0, 0);
        check("press_e5_level", level0, 0);
        edges(1);
        check("press_e6_pulse", pulse0, 1);
        check("press_e6_level", level0, 1);
        check("press_e6_held", held0, 0);
        check("press_e6_pulse_noen", pulse1, 1);
        edges(1);
        check("press_e7_pulse", pulse0, 0);
        edges(19);
        check("repeat_e26_pulse", pulse0, 1);
        check("repeat_e26_held", held0, 1);
        edges(23);
        check("repeat_count_e48", pc0, 4);
        edges(52);
        check("noen_pulse_count", pc1, 1);
        check("noen_held_seen", held1_seen, 0);
        check("noen_level", level1, 1);

        // One-cycle low glitch must not release
        @(negedge clk);
        btn_in = 1'b0;
        #1 rc0 = 0; rc1 = 0;
        drive(1, 1);
        edges(12);
        check("glitch_rel_count", rc0, 0);
        check("glitch_level_en", level0, 1);
        check("glitch_level_noen", level1, 1);

        // Real release
        @(negedge clk);
        btn_in = 1'b0;
        edges(5);
        check("release_e5_rel", rel0, 0);
        check("release_e5_level", level0, 1);
        edges(1);
        check("release_e6_rel", rel0, 1);
        check("release_e6_level", level0, 0);
        check("release_e6_pulse", pulse0, 0);
        check("release_e6_rel_noen", rel1, 1);
        drive(0, 5);

        // Bounce: high 3, low 1, then high
        @(negedge clk);
        btn_in = 1'b1;
        #1 pc0 = 0;
        drive(1, 2);
        drive(0, 1);
        drive(1, 1);
        edges(5);
        check("bounce_e5_pulse", pulse0, 0);
        edges(1);
        check("bounce_e6_pulse", pulse0, 1);
        check("bounce_e6_level", level0, 1);
        drive(1, 4);
        edges(1);
        check("bounce_pulse_count", pc0, 1);
        drive(0, 12);

        // Asynchronous reset while auto-repeating, button held through it
        @(negedge clk);
        btn_in = 1'b1;
        edges(30);
        check("pre_reset_held", held0, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outs_en", int'(outs(0)), 0);
        check("async_reset_outs_noen", int'(outs(1)), 0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 pc0 = 0;
        edges(5);
        check("post_reset_e5_pulse", pulse0, 0);
        check("post_reset_e5_level", level0, 0);
        edges(1);
        check("post_reset_e6_pulse", pulse0, 1);
        check("post_reset_e6_level", level0, 1);
        edges(8);
        check("post_reset_pulse_count", pc0, 1);
        check("post_reset_held", held0, 0);
        drive(0, 12);

        // Randomized runs with occasional asynchronous resets
        while (c < 4000) begin
            int len;
            v   = !v;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 5));
            drive(v, len);
            c += len;
            if ($urandom_range(0, 40) == 0) begin
                @(negedge clk);
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
                c += 2;
            end
        end
        drive(0, 12);
        edges(1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
